qlearn_action_scheduler: RTL and testbench

QLEARN_ACTION_SCHEDULER -- requirements
Module: qlearn_action_scheduler

---
 rtl/qlearn_action_scheduler.sv | 178 +++++++++++++++++
 tb/tb_qlearn_action_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_action_scheduler.sv
// Epsilon-greedy action scheduler for a pipelined Q-learning update engine.
// It tracks in-flight Q-table rows to avoid read-after-write hazards and paces a run to max_steps issues.
module qlearn_action_scheduler #(
    parameter int          PIPE_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [15:0] state_in,
    input  logic [2:0]  greedy_act,
    input  logic        issue_ready,
    input  logic        wb_valid,
    output logic [31:0] alpha,
    output logic [31:0] gamma,
    output logic        issue_valid,
    output logic [2:0]  action,
    output logic [15:0] issue_state,
    output logic [31:0] step_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int PTR_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int OCC_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(PIPE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PIPE_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] RST_RATE      = 32'h3DCCCCCD;
    localparam logic [15:0] RST_EPSILON   = 16'h1999;
    localparam logic [31:0] RST_MAX_STEPS = 32'd1000;
    localparam logic [31:0] STEP_SAT      = 32'hFFFFFFFF;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [31:0]           alpha_r;
    logic [31:0]           gamma_r;
    logic [15:0]           epsilon_r;
    logic [31:0]           max_steps_r;
    logic [31:0]           step_cnt_r;
    logic [31:0]           step_inc_s;
    logic [15:0]           lfsr_r;
    logic                  err_r;
    logic [OCC_W-1:0]      occ_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [15:0]           fifo_mem_r [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] fifo_vld_r;
    logic                  hazard_s;
    logic                  issue_ok_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  wb_err_s;

    // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Hazard: the offered row matches any live entry, including one retiring now.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            hazard_s = hazard_s | (fifo_vld_r[i] & (fifo_mem_r[i] == state_in));
        end
    end

    assign issue_ok_s  = (state_r == ST_RUN) && !hazard_s && (occ_r < OCC_FULL)
                         && (step_cnt_r < max_steps_r);
    assign accept_s    = issue_ok_s & issue_ready;
    assign pop_s       = wb_valid & (occ_r != '0);
    assign wb_err_s    = wb_valid & (occ_r == '0);
    assign step_inc_s  = (step_cnt_r == STEP_SAT) ? step_cnt_r : step_cnt_r + 32'd1;

    assign issue_valid = issue_ok_s;
    assign action      = (lfsr_r < epsilon_r) ? lfsr_r[15:13] : greedy_act;
    assign issue_state = state_in;
    assign alpha       = alpha_r;
    assign gamma       = gamma_r;
    assign step_cnt    = step_cnt_r;
    assign err         = err_r;
    assign busy        = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign done        = (state_r == ST_DONE);

    // Run sequencing; max_steps of zero leaves RUN without issuing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && (step_inc_s == max_steps_r)) state_nxt_s = ST_DRAIN;
                else if (step_cnt_r >= max_steps_r)          state_nxt_s = ST_DRAIN;
                else                                         state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (occ_r == '0) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_DRAIN;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, configuration, step counter, LFSR and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            alpha_r     <= RST_RATE;
            gamma_r     <= RST_RATE;
            epsilon_r   <= RST_EPSILON;
            max_steps_r <= RST_MAX_STEPS;
            step_cnt_r  <= 32'd0;
            lfsr_r      <= LFSR_SEED;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && start) step_cnt_r <= 32'd0;
            else if (accept_s)                 step_cnt_r <= step_inc_s;
            if ((state_r == ST_IDLE) && cfg_we) begin
                case (cfg_addr)
                    2'd0:    alpha_r     <= cfg_wdata;
                    2'd1:    gamma_r     <= cfg_wdata;
                    2'd2:    epsilon_r   <= cfg_wdata[15:0];
                    2'd3:    max_steps_r <= cfg_wdata;
                    default: max_steps_r <= max_steps_r;
                endcase
            end
            if (accept_s) lfsr_r <= lfsr_next(lfsr_r);
            if (wb_err_s) err_r  <= 1'b1;
        end
    end

    // In-flight FIFO bookkeeping: pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            occ_r      <= '0;
            fifo_vld_r <= '0;
        end else begin
            if (pop_s) begin
                fifo_vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r             <= ptr_inc(rd_ptr_r);
            end
            if (accept_s) begin
                fifo_vld_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (accept_s) fifo_mem_r[wr_ptr_r] <= state_in;
    end

endmodule

// File: tb/tb_qlearn_action_scheduler.sv
// Directed self-checking bench for qlearn_action_scheduler.
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later.
module tb_qlearn_action_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [15:0] state_in;
    logic [2:0]  greedy_act;
    logic        issue_ready;
    logic        wb_valid;
    logic [31:0] alpha;
    logic [31:0] gamma;
    logic        issue_valid;
    logic [2:0]  action;
    logic [15:0] issue_state;
    logic [31:0] step_cnt;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  exp_act;

    qlearn_action_scheduler #(.PIPE_DEPTH(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .state_in(state_in), .greedy_act(greedy_act),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .alpha(alpha), .gamma(gamma),
        .issue_valid(issue_valid), .action(action), .issue_state(issue_state),
        .step_cnt(step_cnt), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference LFSR: feedback is the parity of tap bits 15,13,12,10.
    function automatic logic [15:0] model_next(input logic [15:0] v);
        logic [15:0] t;
        t = v & 16'hB400;
        return {v[14:0], ^t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        state_in = 16'd0; greedy_act = 3'd0; issue_ready = 1'b0; wb_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_alpha", alpha, 32'h3DCCCCCD);
        chk("rst_gamma", gamma, 32'h3DCCCCCD);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_step_cnt", step_cnt, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Greedy run: epsilon 0, three issues, write-back two cycles after each.
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd3, 32'd3);
        cfg_write(2'd0, 32'h3F000000);
        #1;
        chk("cfg_alpha", alpha, 32'h3F000000);
        chk("cfg_gamma_kept", gamma, 32'h3DCCCCCD);
        start = 1'b1;
        tick();
        start = 1'b0; issue_ready = 1'b1; state_in = 16'h0010; greedy_act = 3'd3;
        #1;
        chk("g1_busy", {31'd0, busy}, 32'd1);
        chk("g1_step", step_cnt, 32'd0);
        chk("g1_valid", {31'd0, issue_valid}, 32'd1);
        chk("g1_action", {29'd0, action}, 32'd3);
        chk("g1_state", {16'd0, issue_state}, 32'h10);
        tick();
        state_in = 16'h0011; greedy_act = 3'd5;
        #1;
        chk("g2_valid", {31'd0, issue_valid}, 32'd1);
        chk("g2_action", {29'd0, action}, 32'd5);
        chk("g2_step", step_cnt, 32'd1);
        tick();
        state_in = 16'h0012; greedy_act = 3'd6; wb_valid = 1'b1;
        #1;
        chk("g3_valid", {31'd0, issue_valid}, 32'd1);
        chk("g3_action", {29'd0, action}, 32'd6);
        tick();
        state_in = 16'h0013;
        #1;
        chk("g_drain_valid", {31'd0, issue_valid}, 32'd0);
        chk("g_drain_busy", {31'd0, busy}, 32'd1);
        chk("g_drain_step", step_cnt, 32'd3);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; wb_valid = 1'b0;
        #1;
        chk("g_drain_empty_busy", {31'd0, busy}, 32'd1);
        chk("g_drain_empty_done", {31'd0, done}, 32'd0);
        tick();
        chk("g_done_pulse", {31'd0, done}, 32'd1);
        chk("g_done_busy", {31'd0, busy}, 32'd0);
        chk("g_done_step", step_cnt, 32'd3);
        tick();
        chk("g_idle_done", {31'd0, done}, 32'd0);
        chk("g_idle_busy", {31'd0, busy}, 32'd0);

        // Hazard and full-pipeline run, max_steps 8.
        issue_ready = 1'b0;
        cfg_write(2'd3, 32'd8);
        start = 1'b1;
        tick();
        start = 1'b0; issue_ready = 1'b1; state_in = 16'h0005; greedy_act = 3'd1;
        #1;
        chk("h_first_valid", {31'd0, issue_valid}, 32'd1);
        tick();
        chk("h_hold1", {31'd0, issue_valid}, 32'd0);
        tick();
        chk("h_hold2", {31'd0, issue_valid}, 32'd0);
        wb_valid = 1'b1;
        #1;
        chk("h_retiring", {31'd0, issue_valid}, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("h_released", {31'd0, issue_valid}, 32'd1);
        chk("h_step", step_cnt, 32'd1);
        tick();
        state_in = 16'h0020;
        tick();
        state_in = 16'h0021;
        tick();
        state_in = 16'h0022;
        tick();
        state_in = 16'h0023;
        #1;
        chk("f_full_valid", {31'd0, issue_valid}, 32'd0);
        chk("f_full_step", step_cnt, 32'd5);
        wb_valid = 1'b1;
        tick();
        chk("f_issue_wb_valid", {31'd0, issue_valid}, 32'd1);
        tick();
        wb_valid = 1'b0; state_in = 16'h0024;
        #1;
        chk("f_after_simul_valid", {31'd0, issue_valid}, 32'd1);
        chk("f_after_simul_step", step_cnt, 32'd6);
        tick();
        state_in = 16'h0025;
        #1;
        chk("f_refull_valid", {31'd0, issue_valid}, 32'd0);
        chk("f_refull_busy", {31'd0, busy}, 32'd1);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("f_last_valid", {31'd0, issue_valid}, 32'd1);
        tick();
        chk("f_drain_step", step_cnt, 32'd8);
        chk("f_drain_valid", {31'd0, issue_valid}, 32'd0);
        wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wb_valid = 1'b0;
        tick();
        chk("f_done", {31'd0, done}, 32'd1);
        tick();

        // Explore run from the reset seed, with a config write attempted mid-run.
        rst = 1'b1; issue_ready = 1'b0;
        tick();
        rst = 1'b0;
        cfg_write(2'd2, 32'h0000FFFF);
        cfg_write(2'd3, 32'd4);
        m_lfsr = 16'hACE1;
        start = 1'b1;
        tick();
        start = 1'b0; issue_ready = 1'b1; greedy_act = 3'd7;
        for (int i = 0; i < 4; i++) begin
            state_in = 16'h0030 + 16'(i);
            #1;
            exp_act = (m_lfsr < 16'hFFFF) ? m_lfsr[15:13] : 3'd7;
            chk("e_valid", {31'd0, issue_valid}, 32'd1);
            chk("e_action", {29'd0, action}, {29'd0, exp_act});
            if (i == 1) begin
                cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h12345678;
            end else begin
                cfg_we = 1'b0;
            end
            tick();
            m_lfsr = model_next(m_lfsr);
        end
        cfg_we = 1'b0;
        #1;
        chk("e_alpha_kept", alpha, 32'h3DCCCCCD);
        chk("e_drain_busy", {31'd0, busy}, 32'd1);
        chk("e_drain_valid", {31'd0, issue_valid}, 32'd0);
        wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wb_valid = 1'b0;
        tick();
        chk("e_done", {31'd0, done}, 32'd1);
        chk("e_err", {31'd0, err}, 32'd0);
        tick();

        // Reset in the middle of a run with two updates in flight.
        start = 1'b1;
        tick();
        start = 1'b0; state_in = 16'h0040;
        tick();
        state_in = 16'h0041;
        tick();
        chk("r_step_before", step_cnt, 32'd2);
        rst = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd0; wb_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; cfg_we = 1'b0; wb_valid = 1'b0;
        #1;
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_step", step_cnt, 32'd0);
        chk("r_valid", {31'd0, issue_valid}, 32'd0);
        chk("r_alpha", alpha, 32'h3DCCCCCD);
        chk("r_err_clear", {31'd0, err}, 32'd0);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("r_err_set", {31'd0, err}, 32'd1);
        tick();
        chk("r_err_sticky", {31'd0, err}, 32'd1);

        // max_steps of zero: straight through DRAIN without an issue.
        cfg_write(2'd3, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0; state_in = 16'h0050;
        #1;
        chk("z_valid", {31'd0, issue_valid}, 32'd0);
        chk("z_busy_run", {31'd0, busy}, 32'd1);
        tick();
        chk("z_busy_drain", {31'd0, busy}, 32'd1);
        chk("z_step", step_cnt, 32'd0);
        tick();
        chk("z_done", {31'd0, done}, 32'd1);
        tick();
        chk("z_idle", {31'd0, busy | done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
